// File: rtl/cp0_timer_int_if.sv
`default_nettype none
// ============================================================================
// Module   : cp0_timer_int_if
// Purpose  : CP0 register read/write port shared by the timer/interrupt block.
// Revision : 1.0
// ============================================================================
interface cp0_timer_int_if;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [4:0]  raddr;
   logic [31:0] rdata;

   modport master (output we, output waddr, output wdata, output raddr, input rdata);
   modport slave  (input we, input waddr, input wdata, input raddr, output rdata);
endinterface
`default_nettype wire

// File: rtl/cp0_timer_int.sv
`default_nettype none
// ============================================================================
// Module   : cp0_timer_int
// Purpose  : CP0 Count/Compare timer, Cause.IP/TI tracking and interrupt request.
// Revision : 1.0
// ============================================================================
module cp0_timer_int #(
   parameter int HW_INT_N    = 6,
   parameter int COUNT_DIV   = 2,
   parameter int SYNC_STAGES = 2
) (
   input  wire logic                clk,
   input  wire logic                rst,
   cp0_timer_int_if.slave           bus,
   input  wire logic [HW_INT_N-1:0] hw_int_i,
   input  wire logic [7:0]          status_im_i,
   input  wire logic                status_ie_i,
   input  wire logic                status_exl_i,
   output logic [7:0]               ip_o,
   output logic                     timer_int_o,
   output logic                     int_req_o
);
   localparam logic [4:0] c_reg_count   = 5'd9;
   localparam logic [4:0] c_reg_compare = 5'd11;
   localparam logic [4:0] c_reg_cause   = 5'd13;
   localparam logic [3:0] c_div_last    = 4'(COUNT_DIV - 1);

   logic [31:0] count_q, count_d;
   logic [31:0] compare_q, compare_d;
   logic [3:0]  presc_q, presc_d;
   logic        ti_q, ti_d;
   logic [1:0]  sw_ip_q, sw_ip_d;
   logic        int_req_q, int_req_d;
   logic [SYNC_STAGES-1:0][HW_INT_N-1:0] sync_q;

   logic [31:0] w_count_inc;
   logic        w_tick;
   logic [7:0]  w_ip;

   assign w_count_inc = count_q + 32'd1;
   assign w_tick      = (presc_q == c_div_last);

   always_comb begin
      count_d   = count_q;
      compare_d = compare_q;
      presc_d   = presc_q;
      ti_d      = ti_q;
      sw_ip_d   = sw_ip_q;
      // A Count write suppresses both the increment and any match this cycle.
      if (bus.we && bus.waddr == c_reg_count) begin
         count_d = bus.wdata;
         presc_d = 4'd0;
      end else if (w_tick) begin
         count_d = w_count_inc;
         presc_d = 4'd0;
         if (w_count_inc == compare_q)
            ti_d = 1'b1;
      end else begin
         presc_d = presc_q + 4'd1;
      end
      // Compare write comes last so it overrides a coincident match.
      if (bus.we && bus.waddr == c_reg_compare) begin
         compare_d = bus.wdata;
         ti_d      = 1'b0;
      end
      if (bus.we && bus.waddr == c_reg_cause)
         sw_ip_d = bus.wdata[9:8];
   end

   always_comb begin
      w_ip                 = 8'h00;
      w_ip[1:0]            = sw_ip_q;
      w_ip[HW_INT_N+1:2]   = sync_q[SYNC_STAGES-1];
      w_ip[7]              = w_ip[7] | ti_q;
   end

   assign int_req_d = (|(w_ip & status_im_i)) & status_ie_i & ~status_exl_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q   <= 32'h0000_0000;
         compare_q <= 32'hFFFF_FFFF;
         presc_q   <= 4'd0;
         ti_q      <= 1'b0;
         sw_ip_q   <= 2'b00;
         int_req_q <= 1'b0;
         sync_q    <= '0;
      end else begin
         count_q   <= count_d;
         compare_q <= compare_d;
         presc_q   <= presc_d;
         ti_q      <= ti_d;
         sw_ip_q   <= sw_ip_d;
         int_req_q <= int_req_d;
         sync_q    <= {sync_q[SYNC_STAGES-2:0], hw_int_i};
      end
   end

   always_comb begin
      case (bus.raddr)
         c_reg_count:   bus.rdata = count_q;
         c_reg_compare: bus.rdata = compare_q;
         c_reg_cause:   bus.rdata = {1'b0, ti_q, 14'b0, w_ip, 8'b0};
         default:       bus.rdata = 32'h0000_0000;
      endcase
   end

   assign ip_o        = w_ip;
   assign timer_int_o = ti_q;
   assign int_req_o   = int_req_q;
endmodule
`default_nettype wire

// File: tb/tb_cp0_timer_int.sv
`default_nettype none
// ============================================================================
// Module   : tb_cp0_timer_int
// Purpose  : Directed self-checking bench for cp0_timer_int (default params).
// Revision : 1.0
// ============================================================================
module tb_cp0_timer_int;
   logic       clk;
   logic       rst;
   logic [5:0] hw_int_i;
   logic [7:0] status_im_i;
   logic       status_ie_i;
   logic       status_exl_i;
   logic [7:0] ip_o;
   logic       timer_int_o;
   logic       int_req_o;

   cp0_timer_int_if bus_if ();

   cp0_timer_int #(.HW_INT_N(6), .COUNT_DIV(2), .SYNC_STAGES(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus_if),
      .hw_int_i     (hw_int_i),
      .status_im_i  (status_im_i),
      .status_ie_i  (status_ie_i),
      .status_exl_i (status_exl_i),
      .ip_o         (ip_o),
      .timer_int_o  (timer_int_o),
      .int_req_o    (int_req_o)
   );

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic push(input string tag, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      exp_q.push_back(e);
   endtask

   task automatic chk(input logic [31:0] obs);
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $error("FAIL scoreboard_empty observed=%h expected=none", obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e.val) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [4:0] addr, output logic [31:0] data);
      bus_if.raddr = addr;
      #1;
      data = bus_if.rdata;
   endtask

   task automatic wr(input logic [4:0] addr, input logic [31:0] data);
      bus_if.we    = 1'b1;
      bus_if.waddr = addr;
      bus_if.wdata = data;
      cyc(1);
      bus_if.we    = 1'b0;
   endtask

   logic [31:0] d;

   initial begin
      rst          = 1'b1;
      hw_int_i     = '0;
      status_im_i  = 8'h00;
      status_ie_i  = 1'b0;
      status_exl_i = 1'b0;
      bus_if.we    = 1'b0;
      bus_if.waddr = '0;
      bus_if.wdata = '0;
      bus_if.raddr = '0;

      // Reset state
      cyc(2);
      push("rst_count", 32'h0);          rd(5'd9, d);  chk(d);
      push("rst_compare", 32'hFFFFFFFF); rd(5'd11, d); chk(d);
      push("rst_cause", 32'h0);          rd(5'd13, d); chk(d);
      push("rst_ip", 32'h0);             chk({24'h0, ip_o});
      push("rst_int_req", 32'h0);        chk({31'h0, int_req_o});
      rst = 1'b0;

      // Idle counting: 10 edges at divide-by-2
      cyc(10);
      push("idle_count", 32'd5); rd(5'd9, d); chk(d);
      push("idle_ti", 32'h0);    chk({31'h0, timer_int_o});
      push("idle_int_req", 32'h0); chk({31'h0, int_req_o});

      // Count wrap and compare match at 0
      status_im_i = 8'h80;
      status_ie_i = 1'b1;
      wr(5'd9, 32'hFFFF_FFFE);
      wr(5'd11, 32'h0000_0000);
      cyc(1);
      push("wrap_count_ff", 32'hFFFFFFFF); rd(5'd9, d); chk(d);
      cyc(2);
      push("wrap_count_0", 32'h0); rd(5'd9, d); chk(d);
      push("match_ti", 32'h1);     chk({31'h0, timer_int_o});
      push("match_ip7", 32'h1);    chk({31'h0, ip_o[7]});
      push("match_cause", 32'h4000_8000); rd(5'd13, d); chk(d);
      push("match_int_req_lat", 32'h0); chk({31'h0, int_req_o});
      cyc(1);
      push("match_int_req", 32'h1); chk({31'h0, int_req_o});

      // Compare write racing a fresh match
      wr(5'd9, 32'hFFFF_FFFF);
      push("ti_hold", 32'h1); chk({31'h0, timer_int_o});
      cyc(1);
      wr(5'd11, 32'h0000_0100);
      push("race_count", 32'h0);    rd(5'd9, d);  chk(d);
      push("race_ti", 32'h0);       chk({31'h0, timer_int_o});
      push("race_ip7", 32'h0);      chk({31'h0, ip_o[7]});
      push("race_compare", 32'h100); rd(5'd11, d); chk(d);
      cyc(1);
      push("race_int_req", 32'h0);  chk({31'h0, int_req_o});

      // Hardware interrupt synchroniser latency and EXL masking
      status_im_i = 8'h04;
      hw_int_i    = 6'b000001;
      cyc(1);
      push("hw_ip_1cyc", 32'h00); chk({24'h0, ip_o});
      cyc(1);
      push("hw_ip_2cyc", 32'h04); chk({24'h0, ip_o});
      push("hw_req_2cyc", 32'h0); chk({31'h0, int_req_o});
      cyc(1);
      push("hw_req_3cyc", 32'h1); chk({31'h0, int_req_o});
      status_exl_i = 1'b1;
      cyc(1);
      push("exl_mask", 32'h0); chk({31'h0, int_req_o});
      hw_int_i     = '0;
      status_exl_i = 1'b0;
      cyc(3);

      // Software interrupt bits via Cause write
      wr(5'd13, 32'h0000_0300);
      push("sw_ip", 32'h03);         chk({24'h0, ip_o});
      push("sw_cause", 32'h300);     rd(5'd13, d); chk(d);
      push("unmapped_read", 32'h0);  rd(5'd7, d);  chk(d);

      // Asynchronous reset mid-count with prescaler mid-phase
      status_im_i = 8'h01;
      wr(5'd9, 32'd6);
      cyc(3);
      push("pre_rst_count", 32'd7); rd(5'd9, d); chk(d);
      push("pre_rst_req", 32'h1);   chk({31'h0, int_req_o});
      #2;
      rst = 1'b1;
      #1;
      push("arst_count", 32'h0);          rd(5'd9, d);  chk(d);
      push("arst_compare", 32'hFFFFFFFF); rd(5'd11, d); chk(d);
      push("arst_cause", 32'h0);          rd(5'd13, d); chk(d);
      push("arst_ip", 32'h0);             chk({24'h0, ip_o});
      push("arst_ti", 32'h0);             chk({31'h0, timer_int_o});
      push("arst_int_req", 32'h0);        chk({31'h0, int_req_o});
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc(1);
      push("post_rst_1", 32'h0); rd(5'd9, d); chk(d);
      cyc(1);
      push("post_rst_2", 32'h1); rd(5'd9, d); chk(d);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
